// File: rtl/commit_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : commit_unit_if
//  Purpose  : ROB-head inputs and retirement outputs of the commit stage.
//  Revision : 1.0  initial release
// ============================================================================
interface commit_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
);
    logic                  rob_valid;
    logic                  rob_empty;
    logic [3:0]            rob_inst;
    logic [2:0]            rob_dest;
    logic [DATA_WIDTH-1:0] rob_value;
    logic                  rob_predict;
    logic [DATA_WIDTH-1:0] rob_orig_pc;
    logic [3:0]            rob_bht;
    logic [TAG_WIDTH-1:0]  rob_head_tag;
    logic                  rob_re;
    logic                  rf_we;
    logic [2:0]            rf_dest;
    logic [DATA_WIDTH-1:0] rf_data;
    logic [TAG_WIDTH-1:0]  rf_tag;
    logic                  store_commit;
    logic                  bht_we;
    logic [DATA_WIDTH-1:0] bht_pc;
    logic [3:0]            bht_hist;
    logic                  bht_taken;
    logic                  flush;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic [15:0]           stat_commits;
    logic [15:0]           stat_mispred;

    // ROB / environment side
    modport master (
        output rob_valid, rob_empty, rob_inst, rob_dest, rob_value,
               rob_predict, rob_orig_pc, rob_bht, rob_head_tag,
        input  rob_re, rf_we, rf_dest, rf_data, rf_tag, store_commit,
               bht_we, bht_pc, bht_hist, bht_taken, flush, redirect_pc,
               stat_commits, stat_mispred
    );

    // commit unit side
    modport slave (
        input  rob_valid, rob_empty, rob_inst, rob_dest, rob_value,
               rob_predict, rob_orig_pc, rob_bht, rob_head_tag,
        output rob_re, rf_we, rf_dest, rf_data, rf_tag, store_commit,
               bht_we, bht_pc, bht_hist, bht_taken, flush, redirect_pc,
               stat_commits, stat_mispred
    );
endinterface
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : commit_unit
//  Purpose  : In-order retirement from the ROB head: RF writeback, BHT
//             training and mispredict flush/redirect. Optional retire and
//             mispredict counters are built when COMMIT_STATS_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module commit_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int TAG_WIDTH    = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic      clk,
    input  wire logic      reset,
    commit_unit_if.slave   bus
);
    localparam int         c_cnt_w    = $clog2(FLUSH_CYCLES + 1);
    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_stall = 1'b1;
    localparam logic [3:0] c_op_br    = 4'b0000;
    localparam logic [3:0] c_op_stb   = 4'b0011;
    localparam logic [3:0] c_op_stw   = 4'b0111;
    localparam logic [3:0] c_op_sti   = 4'b1011;
    localparam logic [3:0] c_op_jmp   = 4'b1100;

    logic [0:0]            r_state;
    logic [c_cnt_w-1:0]    r_stall_cnt;
    logic                  r_rf_we;
    logic [2:0]            r_rf_dest;
    logic [DATA_WIDTH-1:0] r_rf_data;
    logic [TAG_WIDTH-1:0]  r_rf_tag;
    logic                  r_store_commit;
    logic                  r_bht_we;
    logic [DATA_WIDTH-1:0] r_bht_pc;
    logic [3:0]            r_bht_hist;
    logic                  r_bht_taken;
    logic                  r_flush;
    logic [DATA_WIDTH-1:0] r_redirect_pc;

    logic w_retire;
    logic w_is_br;
    logic w_is_store;
    logic w_writes_rf;
    logic w_taken;
    logic w_mispredict;

    // Reset gates the pop so a ready head is never consumed while held in reset
    assign w_retire     = !reset && (r_state == c_st_run) && !bus.rob_empty && bus.rob_valid;
    assign w_is_br      = (bus.rob_inst == c_op_br);
    assign w_is_store   = (bus.rob_inst == c_op_stb) || (bus.rob_inst == c_op_stw) ||
                          (bus.rob_inst == c_op_sti);
    assign w_writes_rf  = !(w_is_br || w_is_store || (bus.rob_inst == c_op_jmp));
    assign w_taken      = (bus.rob_value != (bus.rob_orig_pc + DATA_WIDTH'(2)));
    assign w_mispredict = w_is_br && (w_taken != bus.rob_predict);

    assign bus.rob_re       = w_retire;
    assign bus.rf_we        = r_rf_we;
    assign bus.rf_dest      = r_rf_dest;
    assign bus.rf_data      = r_rf_data;
    assign bus.rf_tag       = r_rf_tag;
    assign bus.store_commit = r_store_commit;
    assign bus.bht_we       = r_bht_we;
    assign bus.bht_pc       = r_bht_pc;
    assign bus.bht_hist     = r_bht_hist;
    assign bus.bht_taken    = r_bht_taken;
    assign bus.flush        = r_flush;
    assign bus.redirect_pc  = r_redirect_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_run;
            r_stall_cnt    <= '0;
            r_rf_we        <= 1'b0;
            r_rf_dest      <= '0;
            r_rf_data      <= '0;
            r_rf_tag       <= '0;
            r_store_commit <= 1'b0;
            r_bht_we       <= 1'b0;
            r_bht_pc       <= '0;
            r_bht_hist     <= '0;
            r_bht_taken    <= 1'b0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
        end else begin
            // Every registered output is a one-cycle echo of this cycle's retire
            r_rf_we        <= 1'b0;
            r_rf_dest      <= '0;
            r_rf_data      <= '0;
            r_rf_tag       <= '0;
            r_store_commit <= 1'b0;
            r_bht_we       <= 1'b0;
            r_bht_pc       <= '0;
            r_bht_hist     <= '0;
            r_bht_taken    <= 1'b0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
            case (r_state)
                c_st_run: begin
                    if (w_retire) begin
                        if (w_writes_rf) begin
                            r_rf_we   <= 1'b1;
                            r_rf_dest <= bus.rob_dest;
                            r_rf_data <= bus.rob_value;
                            r_rf_tag  <= bus.rob_head_tag;
                        end
                        r_store_commit <= w_is_store;
                        if (w_is_br) begin
                            r_bht_we    <= 1'b1;
                            r_bht_pc    <= bus.rob_orig_pc;
                            r_bht_hist  <= bus.rob_bht;
                            r_bht_taken <= w_taken;
                        end
                        if (w_mispredict) begin
                            r_flush       <= 1'b1;
                            r_redirect_pc <= bus.rob_value;
                            r_state       <= c_st_stall;
                            r_stall_cnt   <= c_cnt_w'(FLUSH_CYCLES);
                        end
                    end
                end
                c_st_stall: begin
                    // Stall spans FLUSH_CYCLES cycles, the flush pulse cycle included
                    if (r_stall_cnt <= c_cnt_w'(1)) begin
                        r_stall_cnt <= '0;
                        r_state     <= c_st_run;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_state     <= c_st_run;
                    r_stall_cnt <= '0;
                end
            endcase
        end
    end

`ifdef COMMIT_STATS_EN
    logic [15:0] r_stat_commits;
    logic [15:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_commits <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (w_retire && (r_stat_commits != 16'hFFFF)) begin
                r_stat_commits <= r_stat_commits + 16'd1;
            end
            if (w_retire && w_mispredict && (r_stat_mispred != 16'hFFFF)) begin
                r_stat_mispred <= r_stat_mispred + 16'd1;
            end
        end
    end

    assign bus.stat_commits = r_stat_commits;
    assign bus.stat_mispred = r_stat_mispred;
`else
    assign bus.stat_commits = '0;
    assign bus.stat_mispred = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_unit
//  Purpose  : Vector table, multi-cycle sequences and random traffic for
//             commit_unit, compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_commit_unit;
    localparam int DW = 16;
    localparam int TW = 3;
    localparam int FC = 2;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_JSR  = 4'h4;
    localparam logic [3:0] OP_STW  = 4'h7;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_TRAP = 4'hF;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        empty;
        logic [3:0]  inst;
        logic [2:0]  dest;
        logic [15:0] value;
        logic        predict;
        logic [15:0] pc;
        logic [3:0]  bht;
        logic [2:0]  tag;
    } in_t;

    typedef struct {
        in_t         in;
        logic        e_re;
        logic        e_rf_we;
        logic        e_store;
        logic        e_bht_we;
        logic        e_taken;
        logic        e_flush;
        logic [15:0] e_redirect;
        logic [15:0] e_rf_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    commit_unit_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    commit_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: remaining stalled cycles and statistic totals
    int m_stall   = 0;
    int m_commits = 0;
    int m_mispred = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic in_t mk(input logic rst, input logic valid, input logic empty,
                               input logic [3:0] inst, input logic [2:0] dest,
                               input logic [15:0] value, input logic predict,
                               input logic [15:0] pc, input logic [3:0] bht,
                               input logic [2:0] tag);
        in_t v;
        v.rst = rst; v.valid = valid; v.empty = empty; v.inst = inst; v.dest = dest;
        v.value = value; v.predict = predict; v.pc = pc; v.bht = bht; v.tag = tag;
        return v;
    endfunction

    function automatic vec_t mv(input in_t v, input logic re, input logic rfwe,
                                input logic st, input logic bw, input logic tk,
                                input logic fl, input logic [15:0] red,
                                input logic [15:0] data);
        vec_t t;
        t.in = v; t.e_re = re; t.e_rf_we = rfwe; t.e_store = st; t.e_bht_we = bw;
        t.e_taken = tk; t.e_flush = fl; t.e_redirect = red; t.e_rf_data = data;
        return t;
    endfunction

    // Apply one cycle of inputs and check every output against the model
    task automatic cycle(input in_t v, output logic got_re);
        logic        e_re, is_br, is_st, taken;
        logic        e_rf_we, e_store, e_bht_we, e_taken, e_flush;
        logic [2:0]  e_dest, e_tag;
        logic [3:0]  e_hist;
        logic [15:0] e_data, e_bpc, e_redir, e_sc, e_sm;
        reset            = v.rst;
        bus.rob_valid    = v.valid;
        bus.rob_empty    = v.empty;
        bus.rob_inst     = v.inst;
        bus.rob_dest     = v.dest;
        bus.rob_value    = v.value;
        bus.rob_predict  = v.predict;
        bus.rob_orig_pc  = v.pc;
        bus.rob_bht      = v.bht;
        bus.rob_head_tag = v.tag;
        #1;
        e_re   = !v.rst && (m_stall == 0) && !v.empty && v.valid;
        got_re = bus.rob_re;
        chk("rob_re", bus.rob_re, e_re);

        e_rf_we = 0; e_store = 0; e_bht_we = 0; e_taken = 0; e_flush = 0;
        e_dest = 0; e_tag = 0; e_hist = 0; e_data = 0; e_bpc = 0; e_redir = 0;
        if (v.rst) begin
            m_stall = 0; m_commits = 0; m_mispred = 0;
        end else if (m_stall > 0) begin
            m_stall--;
        end else if (e_re) begin
            is_br   = (v.inst == OP_BR);
            is_st   = (v.inst == OP_STB) || (v.inst == OP_STW) || (v.inst == OP_STI);
            e_rf_we = !(is_br || is_st || (v.inst == OP_JMP));
            if (e_rf_we) begin
                e_dest = v.dest; e_data = v.value; e_tag = v.tag;
            end
            e_store = is_st;
            if (is_br) begin
                taken    = (int'(v.value) != ((int'(v.pc) + 2) % 65536));
                e_bht_we = 1; e_bpc = v.pc; e_hist = v.bht; e_taken = taken;
                if (taken != v.predict) begin
                    e_flush = 1; e_redir = v.value; m_stall = FC;
                    if (m_mispred < 65535) m_mispred++;
                end
            end
            if (m_commits < 65535) m_commits++;
        end
`ifdef COMMIT_STATS_EN
        e_sc = 16'(m_commits); e_sm = 16'(m_mispred);
`else
        e_sc = 16'h0; e_sm = 16'h0;
`endif
        @(posedge clk);
        #1;
        chk("rf_we",        bus.rf_we,        e_rf_we);
        chk("rf_dest",      bus.rf_dest,      e_dest);
        chk("rf_data",      bus.rf_data,      e_data);
        chk("rf_tag",       bus.rf_tag,       e_tag);
        chk("store_commit", bus.store_commit, e_store);
        chk("bht_we",       bus.bht_we,       e_bht_we);
        chk("bht_pc",       bus.bht_pc,       e_bpc);
        chk("bht_hist",     bus.bht_hist,     e_hist);
        chk("bht_taken",    bus.bht_taken,    e_taken);
        chk("flush",        bus.flush,        e_flush);
        chk("redirect_pc",  bus.redirect_pc,  e_redir);
        chk("stat_commits", bus.stat_commits, e_sc);
        chk("stat_mispred", bus.stat_mispred, e_sm);
    endtask

    vec_t vecs[21];

    initial begin
        logic got;
        in_t  r;
        reset = 1'b1;
        bus.rob_valid = 0; bus.rob_empty = 1; bus.rob_inst = 0; bus.rob_dest = 0;
        bus.rob_value = 0; bus.rob_predict = 0; bus.rob_orig_pc = 0; bus.rob_bht = 0;
        bus.rob_head_tag = 0;

        vecs[0]  = mv(mk(1,1,0,OP_ADD,3,16'h1234,0,16'h0010,0,5), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[1]  = mv(mk(1,1,0,OP_ADD,3,16'h1234,0,16'h0010,0,5), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[2]  = mv(mk(0,1,0,OP_ADD,3,16'h1234,0,16'h0010,0,5), 1,1,0,0,0,0,16'h0,16'h1234);
        vecs[3]  = mv(mk(0,1,0,OP_BR,0,16'h0042,0,16'h0040,4'hA,1), 1,0,0,1,0,0,16'h0,16'h0);
        vecs[4]  = mv(mk(0,1,0,OP_BR,0,16'h0080,0,16'h0040,4'h5,2), 1,0,0,1,1,1,16'h0080,16'h0);
        vecs[5]  = mv(mk(0,1,0,OP_ADD,1,16'h1111,0,16'h0,0,3), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[6]  = mv(mk(0,1,0,OP_ADD,1,16'h1111,0,16'h0,0,3), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[7]  = mv(mk(0,1,0,OP_ADD,1,16'h1111,0,16'h0,0,3), 1,1,0,0,0,0,16'h0,16'h1111);
        vecs[8]  = mv(mk(0,0,0,OP_STB,2,16'h5555,0,16'h0,0,4), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[9]  = mv(mk(0,1,0,OP_STB,2,16'h5555,0,16'h0,0,4), 1,0,1,0,0,0,16'h0,16'h0);
        vecs[10] = mv(mk(0,1,1,OP_ADD,2,16'h6666,0,16'h0,0,4), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[11] = mv(mk(0,1,0,OP_BR,0,16'h0000,1,16'hFFFE,4'h3,6), 1,0,0,1,0,1,16'h0000,16'h0);
        vecs[12] = mv(mk(0,1,0,OP_JSR,7,16'h3000,0,16'h0200,0,7), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[13] = mv(mk(0,1,0,OP_JSR,7,16'h3000,0,16'h0200,0,7), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[14] = mv(mk(0,1,0,OP_JSR,7,16'h3000,0,16'h0200,0,7), 1,1,0,0,0,0,16'h0,16'h3000);
        vecs[15] = mv(mk(0,1,0,OP_JMP,0,16'h4000,0,16'h0,0,0), 1,0,0,0,0,0,16'h0,16'h0);
        vecs[16] = mv(mk(0,1,0,OP_BR,0,16'h0200,0,16'h0100,0,1), 1,0,0,1,1,1,16'h0200,16'h0);
        vecs[17] = mv(mk(1,1,0,OP_ADD,5,16'h7777,0,16'h0,0,2), 0,0,0,0,0,0,16'h0,16'h0);
        vecs[18] = mv(mk(0,1,0,OP_TRAP,7,16'h0ABC,0,16'h0,0,3), 1,1,0,0,0,0,16'h0,16'h0ABC);
        vecs[19] = mv(mk(0,1,0,OP_BR,0,16'h0300,1,16'h0100,0,4), 1,0,0,1,1,0,16'h0,16'h0);
        vecs[20] = mv(mk(0,1,0,OP_STW,1,16'h0F0F,0,16'h0,0,5), 1,0,1,0,0,0,16'h0,16'h0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            cycle(vecs[i].in, got);
            chk($sformatf("vec%0d re", i),       got,              vecs[i].e_re);
            chk($sformatf("vec%0d rf_we", i),    bus.rf_we,        vecs[i].e_rf_we);
            chk($sformatf("vec%0d store", i),    bus.store_commit, vecs[i].e_store);
            chk($sformatf("vec%0d bht_we", i),   bus.bht_we,       vecs[i].e_bht_we);
            chk($sformatf("vec%0d taken", i),    bus.bht_taken,    vecs[i].e_taken);
            chk($sformatf("vec%0d flush", i),    bus.flush,        vecs[i].e_flush);
            chk($sformatf("vec%0d redirect", i), bus.redirect_pc,  vecs[i].e_redirect);
            chk($sformatf("vec%0d rf_data", i),  bus.rf_data,      vecs[i].e_rf_data);
        end

        // Statistics sequence: three retires, one of them mispredicting
        cycle(mk(1,0,1,OP_ADD,0,16'h0,0,16'h0,0,0), got);
        cycle(mk(0,1,0,OP_ADD,2,16'h0001,0,16'h0,0,1), got);
        cycle(mk(0,1,0,OP_BR,0,16'h0500,0,16'h0100,0,2), got);
        cycle(mk(0,1,0,OP_ADD,2,16'h0002,0,16'h0,0,3), got);
        cycle(mk(0,1,0,OP_ADD,2,16'h0002,0,16'h0,0,3), got);
        cycle(mk(0,1,0,OP_ADD,2,16'h0002,0,16'h0,0,3), got);
`ifdef COMMIT_STATS_EN
        chk("seq stat_commits", bus.stat_commits, 32'd3);
        chk("seq stat_mispred", bus.stat_mispred, 32'd1);
`else
        chk("seq stat_commits", bus.stat_commits, 32'd0);
        chk("seq stat_mispred", bus.stat_mispred, 32'd0);
`endif

        // Random traffic, branch targets often equal pc+2 to exercise both outcomes
        for (int n = 0; n < 500; n++) begin
            r.rst     = ($urandom_range(0, 59) == 0);
            r.valid   = ($urandom_range(0, 3) != 0);
            r.empty   = ($urandom_range(0, 5) == 0);
            r.inst    = ($urandom_range(0, 2) == 0) ? OP_BR : 4'($urandom);
            r.dest    = 3'($urandom);
            r.pc      = 16'($urandom);
            r.value   = ($urandom_range(0, 1) == 1) ? 16'(r.pc + 16'd2) : 16'($urandom);
            r.predict = 1'($urandom);
            r.bht     = 4'($urandom);
            r.tag     = 3'($urandom);
            cycle(r, got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
